// File: rtl/stream_writer.sv
// stream_writer: streams nine post-collision distributions per cell to their neighbour addresses.
// Optional STREAM_BOUNCEBACK_EN reflects vertical-edge distributions back into the source cell.
module stream_writer #(
  parameter int GRID_W = 64,
  parameter int GRID_H = 32,
  parameter int ADDR_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic signed [15:0] f_null,
  input  logic signed [15:0] f_n,
  input  logic signed [15:0] f_ne,
  input  logic signed [15:0] f_e,
  input  logic signed [15:0] f_se,
  input  logic signed [15:0] f_s,
  input  logic signed [15:0] f_sw,
  input  logic signed [15:0] f_w,
  input  logic signed [15:0] f_nw,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [3:0]         wr_dir,
  output logic [15:0]        wr_data,
  output logic               frame_done
);
  localparam int XW = GRID_W > 1 ? $clog2(GRID_W) : 1;
  localparam int YW = GRID_H > 1 ? $clog2(GRID_H) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d, nx;
  logic [YW-1:0] y_q, y_d, ny;
  logic [3:0] k_q, k_d, dir;
  logic [8:0][15:0] f_q, f_d;
  logic in_ready_q, fd_q, fd_d;
  logic acc, hs, xp, xm, yp, ym;

  assign acc = in_valid && in_ready_q;
  assign hs = state_q == EMIT && wr_ready;
  assign xp = k_q inside {4'd2, 4'd3, 4'd4};
  assign xm = k_q inside {4'd6, 4'd7, 4'd8};
  assign yp = k_q inside {4'd1, 4'd2, 4'd8};
  assign ym = k_q inside {4'd4, 4'd5, 4'd6};

  // Neighbour of the source cell for direction k, periodic unless bounced.
  always_comb begin
    nx = xp ? (x_q == X_MAX ? '0 : x_q + 1'b1) : xm ? (x_q == '0 ? X_MAX : x_q - 1'b1) : x_q;
    ny = yp ? (y_q == Y_MAX ? '0 : y_q + 1'b1) : ym ? (y_q == '0 ? Y_MAX : y_q - 1'b1) : y_q;
    dir = k_q;
`ifdef STREAM_BOUNCEBACK_EN
    if ((ym && y_q == '0) || (yp && y_q == Y_MAX)) begin
      nx = x_q;
      ny = y_q;
      dir = k_q > 4'd4 ? k_q - 4'd4 : k_q + 4'd4;
    end
`endif
  end

  assign in_ready = in_ready_q;
  assign wr_valid = state_q == EMIT;
  assign wr_dir = dir;
  assign wr_data = f_q[k_q];
  assign wr_addr = ADDR_W'(ny) * ADDR_W'(GRID_W) + ADDR_W'(nx);
  assign frame_done = fd_q;

  always_comb begin
    state_d = state_q;
    k_d = k_q;
    x_d = x_q;
    y_d = y_q;
    f_d = f_q;
    fd_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      k_d = '0;
      x_d = '0;
      y_d = '0;
    end else if (acc) begin
      state_d = EMIT;
      k_d = '0;
      f_d = {f_nw, f_w, f_sw, f_s, f_se, f_e, f_ne, f_n, f_null};
    end else if (hs && k_q == 4'd8) begin
      state_d = IDLE;
      k_d = '0;
      x_d = x_q == X_MAX ? '0 : x_q + 1'b1;
      y_d = x_q == X_MAX ? (y_q == Y_MAX ? '0 : y_q + 1'b1) : y_q;
      fd_d = x_q == X_MAX && y_q == Y_MAX;
    end else if (hs) begin
      k_d = k_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      x_q <= '0;
      y_q <= '0;
      f_q <= '0;
      fd_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      x_q <= x_d;
      y_q <= y_d;
      f_q <= f_d;
      fd_q <= fd_d;
      in_ready_q <= state_d == IDLE;
    end
  end
endmodule

// File: doc/stream_writer.md
STREAM_WRITER -- requirements
Module: stream_writer

Interface
REQ-001 The block SHALL have parameter GRID_W, default 64, meaning lattice width in cells.
REQ-002 The block SHALL have parameter GRID_H, default 32, meaning lattice height in cells.
REQ-003 The block SHALL have parameter ADDR_W, default 11, meaning write-address width, with 2^ADDR_W >= GRID_W*GRID_H.
REQ-004 The block SHALL have port clk, input, 1 bit, system clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset rst, asynchronous, active-high; clock clk.
REQ-006 The block SHALL have port clear, input, 1 bit, synchronous frame restart.
REQ-007 The block SHALL have ports f_null, f_n, f_ne, f_e, f_se, f_s, f_sw, f_w, f_nw, input, 16 bits each, signed post-collision distributions (Q2.13).
REQ-008 The block SHALL have port in_valid, input, 1 bit, distribution set valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit, block can accept a set.
REQ-010 The block SHALL have port wr_valid, output, 1 bit, write request valid.
REQ-011 The block SHALL have port wr_ready, input, 1 bit, memory accepts write.
REQ-012 The block SHALL have port wr_addr, output, ADDR_W bits, destination cell address y*GRID_W+x.
REQ-013 The block SHALL have port wr_dir, output, 4 bits, destination direction index 0..8 (null,n,ne,e,se,s,sw,w,nw).
REQ-014 The block SHALL have port wr_data, output, 16 bits, distribution value.
REQ-015 The block SHALL have port frame_done, output, 1 bit, one-cycle end-of-frame pulse.

Function
REQ-016 The block SHALL track source cell (x,y) in raster order: x increments first, x wraps GRID_W-1 -> 0 with y increment, starting at (0,0).
REQ-017 The FSM SHALL have states IDLE and EMIT; in_ready SHALL equal 1 only in IDLE.
REQ-018 On in_valid&&in_ready the block SHALL register all nine inputs, set direction counter k=0, and enter EMIT; wr_valid SHALL rise the next cycle.
REQ-019 In EMIT, wr_dir=k and wr_data=f_k; wr_addr SHALL be the neighbour cell per direction, where n=y+1, s=y-1, e=x+1, w=x-1, diagonals combined, null=(x,y).
REQ-020 Neighbour coordinates SHALL wrap periodically in both axes (x=-1 -> GRID_W-1, y=GRID_H -> 0, etc.).
REQ-021 While wr_valid&&!wr_ready, wr_addr, wr_dir and wr_data SHALL remain stable.
REQ-022 On each wr_valid&&wr_ready handshake k SHALL increment; handshake at k=8 SHALL advance (x,y) and return to IDLE.
REQ-023 Handshake at k=8 for cell (GRID_W-1,GRID_H-1) SHALL wrap (x,y) to (0,0) and assert frame_done in the following cycle only.
REQ-024 Throughput SHALL be at most one cell per 10 cycles (1 accept + 9 writes) with wr_ready held high.
REQ-025 clear SHALL, in any state, return FSM to IDLE, drop the in-flight cell, set (x,y)=(0,0), deassert wr_valid next cycle, and suppress frame_done; clear takes priority over any simultaneous handshake.

Reset
REQ-026 While rst is high, state=IDLE, (x,y)=(0,0), k=0, wr_valid=0, frame_done=0, in_ready=0, wr_addr=0, wr_dir=0, wr_data=0, held registers=0.
REQ-027 in_ready SHALL rise the first clock after rst deasserts; reset mid-EMIT SHALL abandon the cell with no further writes.

Configuration
REQ-028 With macro STREAM_BOUNCEBACK_EN defined, distributions leaving through y=0 (dirs se,s,sw) or y=GRID_H-1 (dirs n,ne,nw) SHALL be written to the source cell address with the opposite direction (1<->5, 2<->6, 4<->8) instead of wrapping vertically.
REQ-029 Without STREAM_BOUNCEBACK_EN, all boundaries SHALL be periodic per REQ-020; horizontal edges SHALL be periodic in both builds.

Verification (GRID_W=4, GRID_H=4, ADDR_W=4)
REQ-030 Cell (0,0), f_k=100+k, wr_ready=1 -> writes (dir,addr,data): (0,0,100),(1,4,101),(2,5,102),(3,1,103),(4,13,104),(5,12,105),(6,15,106),(7,3,107),(8,7,108) on 9 consecutive cycles.
REQ-031 Same stimulus with STREAM_BOUNCEBACK_EN -> dirs 4,5,6 become (8,0,104),(1,0,105),(2,0,106); others unchanged.
REQ-032 wr_ready low 3 cycles during k=2 -> wr_addr=5, wr_dir=2, wr_data=102 held stable; no skipped or duplicated writes.
REQ-033 16 cells streamed -> frame_done pulses exactly once, one cycle after cell 15's k=8 handshake; next cell writes dir0 to addr 0.
REQ-034 clear asserted at k=4 of cell 5 -> wr_valid low next cycle, in_ready high, next accepted cell writes dir0 to addr 0.
REQ-035 rst pulsed mid-EMIT -> all outputs zero during reset, no writes afterwards until a new in_valid handshake.
